// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared bank/sequencer types and bank-table sizing for the HDMI frame scheduler
package hdmi_pkg;
   localparam int NUM_BANKS = 3;
   localparam int BANK_W = 2;
   typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_DISPLAY} bank_state_e;
   typedef enum logic [1:0] {S_WAIT_LOCK, S_SETTLE, S_BLANK, S_RUN} seq_state_e;
endpackage

// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl: triple-buffer bank table with writer grant/done handshake, frame swap and drop count
//   clk_i/rst_ni  clock, async active-low reset
//   swap_req_i    frame-start strobe qualified with RUN
//   wr_req_i      writer bank request; wr_done_i writer finished granted bank
//   wr_grant_o    1-cycle grant pulse; wr_bank_o granted bank; wr_busy_o a bank is WRITING
//   rd_bank_o     bank on display; drop_cnt_o READY frames discarded (saturating)
module frame_bank_ctrl
   import hdmi_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              swap_req_i,
   input  logic              wr_req_i,
   input  logic              wr_done_i,
   output logic              wr_grant_o,
   output logic [BANK_W-1:0] wr_bank_o,
   output logic              wr_busy_o,
   output logic [BANK_W-1:0] rd_bank_o,
   output logic [7:0]        drop_cnt_o
);
   bank_state_e bank_q [NUM_BANKS];
   bank_state_e bank_d [NUM_BANKS];
   logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, wr_idx, rdy_idx, free_idx;
   logic [7:0] drop_q, drop_d;
   logic wr_grant_q, writing, ready, grant, done, swap;
   always_comb begin
      writing = 1'b0;
      ready = 1'b0;
      wr_idx = '0;
      rdy_idx = '0;
      free_idx = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         if (bank_q[i] == B_WRITING) begin
            writing = 1'b1;
            wr_idx = BANK_W'(i);
         end
         if (bank_q[i] == B_READY) begin
            ready = 1'b1;
            rdy_idx = BANK_W'(i);
         end
         if (bank_q[i] == B_FREE) free_idx = BANK_W'(i);
      end
   end
   // swap consumes the READY bank from before this cycle, so a coincident done never counts as a drop
   always_comb begin
      grant = wr_req_i & ~writing;
      done = wr_done_i & writing;
      swap = swap_req_i & ready;
      bank_d = bank_q;
      rd_bank_d = swap ? rdy_idx : rd_bank_q;
      wr_bank_d = grant ? free_idx : wr_bank_q;
      drop_d = (done && ready && !swap && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      if (swap) begin
         bank_d[rdy_idx] = B_DISPLAY;
         bank_d[rd_bank_q] = B_FREE;
      end
      if (done) begin
         if (ready && !swap) bank_d[rdy_idx] = B_FREE;
         bank_d[wr_idx] = B_READY;
      end
      if (grant) bank_d[free_idx] = B_WRITING;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bank_q <= '{B_DISPLAY, B_FREE, B_FREE};
         wr_bank_q <= '0;
         rd_bank_q <= '0;
         wr_grant_q <= 1'b0;
         drop_q <= '0;
      end else begin
         bank_q <= bank_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_grant_q <= grant;
         drop_q <= drop_d;
      end
   end
   assign wr_grant_o = wr_grant_q;
   assign wr_bank_o = wr_bank_q;
   assign wr_busy_o = writing;
   assign rd_bank_o = rd_bank_q;
   assign drop_cnt_o = drop_q;
endmodule

// File: rtl/hdmi_frame_scheduler.sv
// hdmi_frame_scheduler: HDMI bring-up sequencer and triple-buffer frame scheduling in the pixel domain
//   pixel_clk/sys_rst_n  clock, async active-low reset
//   locked               async PLL lock; video_vs vsync from timing generator
//   wr_req/wr_done       writer handshake in; wr_grant/wr_bank/wr_busy writer handshake out
//   rd_bank              bank scanned out; out_en TMDS enable (RUN only)
//   frame_cnt            frame starts seen in RUN; drop_cnt discarded READY frames
module hdmi_frame_scheduler
   import hdmi_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1024,
   parameter int BLANK_FRAMES = 2,
   parameter bit VS_ACTIVE_HIGH = 1'b1,
   parameter int FCNT_W = 16
) (
   input  logic              pixel_clk,
   input  logic              sys_rst_n,
   input  logic              locked,
   input  logic              video_vs,
   input  logic              wr_req,
   input  logic              wr_done,
   output logic              wr_grant,
   output logic [BANK_W-1:0] wr_bank,
   output logic              wr_busy,
   output logic [BANK_W-1:0] rd_bank,
   output logic              out_en,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic [7:0]        drop_cnt
);
   localparam int CNT_W = ($clog2(SETTLE_CYCLES) > 4) ? $clog2(SETTLE_CYCLES) + 1 : 5;
   seq_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic lk_meta_q, lk_q, vs_q, fs_q, fs_d, out_en_q, out_en_d, run;
   assign fs_d = VS_ACTIVE_HIGH ? (video_vs & ~vs_q) : (~video_vs & vs_q);
   assign run = (state_q == S_RUN) & lk_q;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      case (state_q)
         S_WAIT_LOCK: begin
            state_d = S_SETTLE;
            cnt_d = '0;
         end
         S_SETTLE: begin
            state_d = (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? S_BLANK : S_SETTLE;
            cnt_d = (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
         end
         S_BLANK: begin
            state_d = (fs_q && cnt_q == CNT_W'(BLANK_FRAMES - 1)) ? S_RUN : S_BLANK;
            cnt_d = fs_q ? cnt_q + CNT_W'(1) : cnt_q;
         end
         default: state_d = S_RUN;
      endcase
      if (!lk_q) begin
         state_d = S_WAIT_LOCK;
         cnt_d = '0;
      end
      // enable lags RUN entry by a cycle but drops in the same cycle RUN is left
      out_en_d = (state_q == S_RUN) && (state_d == S_RUN);
      frame_cnt_d = (fs_q && run) ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
   end
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lk_meta_q <= 1'b0;
         lk_q <= 1'b0;
         vs_q <= ~VS_ACTIVE_HIGH;
         fs_q <= 1'b0;
         state_q <= S_WAIT_LOCK;
         cnt_q <= '0;
         out_en_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         lk_meta_q <= locked;
         lk_q <= lk_meta_q;
         vs_q <= video_vs;
         fs_q <= fs_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         out_en_q <= out_en_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
   frame_bank_ctrl u_banks (
      .clk_i      (pixel_clk),
      .rst_ni     (sys_rst_n),
      .swap_req_i (fs_q & run),
      .wr_req_i   (wr_req),
      .wr_done_i  (wr_done),
      .wr_grant_o (wr_grant),
      .wr_bank_o  (wr_bank),
      .wr_busy_o  (wr_busy),
      .rd_bank_o  (rd_bank),
      .drop_cnt_o (drop_cnt)
   );
   assign out_en = out_en_q;
   assign frame_cnt = frame_cnt_q;
endmodule
